mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4: consecutive MEM grants while IF waits before IF is forced.
REQ-004 SHALL have parameter TIMEOUT, default 255: wait cycles before abort; 0 disables timeout.
REQ-005 SHALL have one clock and asynchronous active-low reset. Ports: clk_in (in, 1, clock); n_rst_in (in, 1, async active-low reset).
REQ-006 SHALL have IF-side ports: if_req_in (in, 1, fetch request); if_addr_in (in, ADDR_W, fetch address); if_data_out (out, DATA_W, fetched word); if_ack_out (out, 1, one-cycle completion).
REQ-007 SHALL have MEM-side ports: mem_req_in (in, 1); mem_we_in (in, 1, 1=store); mem_addr_in (in, ADDR_W); mem_wdata_in (in, DATA_W); mem_rdata_out (out, DATA_W); mem_ack_out (out, 1).
REQ-008 SHALL have RAM-side ports: ram_req_out (out, 1); ram_we_out (out, 1); ram_addr_out (out, ADDR_W); ram_wdata_out (out, DATA_W); ram_rdata_in (in, DATA_W); ram_ready_in (in, 1, access done this cycle).
REQ-009 SHALL have status ports: stall_if_out (out, 1); stall_mem_out (out, 1); err_timeout_out (out, 1, sticky).

Function
REQ-010 SHALL implement FSM states IDLE, BUSY_IF, BUSY_MEM, ACK; all ram_*, *_ack, *_data and err outputs registered.
REQ-011 SHALL, in IDLE with any request, latch address/we/wdata of the winner into ram_* and enter BUSY_IF or BUSY_MEM; ram_req_out high from the next cycle.
REQ-012 SHALL grant MEM over IF when both request, unless the starve counter equals STARVE_MAX, then grant IF.
REQ-013 SHALL increment the starve counter on each MEM grant with if_req_in high, clear it on IF grant or on MEM grant with if_req_in low; the counter saturates at STARVE_MAX.
REQ-014 SHALL hold all ram_* outputs stable in BUSY_x while ram_req_out is high and ram_ready_in is low.
REQ-015 SHALL, on ram_ready_in high in BUSY_x, drop ram_req_out next cycle, enter ACK, pulse the matching ack for exactly that cycle, and load ram_rdata_in into if_data_out or mem_rdata_out.
REQ-016 SHALL leave mem_rdata_out unchanged on store completion (ram_we_out=1).
REQ-017 SHALL grant nothing in ACK and return to IDLE next cycle; minimum request-to-ack latency is 2 cycles, minimum grant spacing is 3 cycles.
REQ-018 SHALL ignore ram_ready_in outside BUSY_x.
REQ-019 SHALL count BUSY_x cycles with ram_ready_in low; when TIMEOUT!=0 and count reaches TIMEOUT: drop ram_req_out, enter ACK, ack the requester with data 0, and set err_timeout_out until reset.
REQ-020 SHALL drive stall_if_out = if_req_in AND NOT if_ack_out, and stall_mem_out = mem_req_in AND NOT mem_ack_out, combinationally.
REQ-021 SHALL require requesters to hold req and payload until their ack; a request dropped before ack is still completed and acked.

Reset
REQ-022 SHALL, on n_rst_in low, asynchronously enter IDLE and clear all registered outputs, starve counter, wait counter and err_timeout_out to 0.
REQ-023 SHALL discard any in-flight access on reset with no ack; the first grant is evaluated on the first rising edge with n_rst_in high.

Verification
REQ-024 SHALL cover: IF-only read of 0x40, ram_ready_in 1 on first req cycle, rdata 0xDEADBEEF -> if_ack_out pulses at cycle 2, if_data_out=0xDEADBEEF.
REQ-025 SHALL cover: simultaneous IF and MEM load -> MEM served first, IF served after ACK; stall_if_out high throughout until its ack.
REQ-026 SHALL cover: IF held and MEM continuously requesting, STARVE_MAX=4 -> 4 MEM grants, then IF grant, counter returns to 0.
REQ-027 SHALL cover: MEM store 0x1234 to 0x80 with 3 wait cycles -> ram_we_out=1, outputs stable for 4 cycles, mem_ack_out pulses, mem_rdata_out unchanged.
REQ-028 SHALL cover: ram_ready_in never asserted, TIMEOUT=8 -> abort after 8 wait cycles, ack with data 0, err_timeout_out stays 1 until reset.
REQ-029 SHALL cover: n_rst_in low mid BUSY_MEM -> all outputs 0 immediately, no ack; pending IF request granted first after reset release.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch / load-store) arbiter in front of a single-ported RAM
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk_in,
  input  logic              n_rst_in,
  // instruction-fetch requester
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic [DATA_W-1:0] if_data_out,
  output logic              if_ack_out,
  // load/store requester
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_wdata_in,
  output logic [DATA_W-1:0] mem_rdata_out,
  output logic              mem_ack_out,
  // RAM port
  output logic              ram_req_out,
  output logic              ram_we_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [DATA_W-1:0] ram_wdata_out,
  input  logic [DATA_W-1:0] ram_rdata_in,
  input  logic              ram_ready_in,
  // status
  output logic              stall_if_out,
  output logic              stall_mem_out,
  output logic              err_timeout_out
);

  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  // the abort fires on the wait cycle that brings the count to TIMEOUT
  localparam logic [TW-1:0] WAIT_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2,
    ACK      = 2'd3
  } state_t;

  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic [TW-1:0]   wait_cnt;
  logic            pick_if;

  // MEM normally wins; IF wins when alone or once MEM has starved it STARVE_MAX times
  assign pick_if = if_req_in && (!mem_req_in || (starve_cnt == STARVE_LIM));

  // a requester is stalled whenever it asks and is not being acked this cycle
  assign stall_if_out  = if_req_in  & ~if_ack_out;
  assign stall_mem_out = mem_req_in & ~mem_ack_out;

  // arbitration FSM with every RAM-side and requester-side output registered
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      state           <= IDLE;
      starve_cnt      <= '0;
      wait_cnt        <= '0;
      ram_req_out     <= 1'b0;
      ram_we_out      <= 1'b0;
      ram_addr_out    <= '0;
      ram_wdata_out   <= '0;
      if_data_out     <= '0;
      if_ack_out      <= 1'b0;
      mem_rdata_out   <= '0;
      mem_ack_out     <= 1'b0;
      err_timeout_out <= 1'b0;
    end else begin
      if_ack_out  <= 1'b0;
      mem_ack_out <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req_in || mem_req_in) begin
            ram_req_out <= 1'b1;
            wait_cnt    <= '0;
            if (pick_if) begin
              state         <= BUSY_IF;
              ram_we_out    <= 1'b0;
              ram_addr_out  <= if_addr_in;
              ram_wdata_out <= '0;
              starve_cnt    <= '0;
            end else begin
              state         <= BUSY_MEM;
              ram_we_out    <= mem_we_in;
              ram_addr_out  <= mem_addr_in;
              ram_wdata_out <= mem_wdata_in;
              if (!if_req_in) begin
                starve_cnt <= '0;
              end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end
          end
        end
        BUSY_IF, BUSY_MEM: begin
          if (ram_ready_in) begin
            ram_req_out <= 1'b0;
            state       <= ACK;
            if (state == BUSY_IF) begin
              if_ack_out  <= 1'b1;
              if_data_out <= ram_rdata_in;
            end else begin
              mem_ack_out <= 1'b1;
              // a store returns no data, so the last load result is kept
              if (!ram_we_out) mem_rdata_out <= ram_rdata_in;
            end
          end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
            ram_req_out     <= 1'b0;
            state           <= ACK;
            err_timeout_out <= 1'b1;
            if (state == BUSY_IF) begin
              if_ack_out  <= 1'b1;
              if_data_out <= '0;
            end else begin
              mem_ack_out   <= 1'b1;
              mem_rdata_out <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ACK: begin
          // the acked requester gets this cycle to drop its request
          state    <= IDLE;
          wait_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam logic [31:0] K = 32'h5A5A_5A5A;

  logic        clk_in, n_rst_in;
  logic        if_req_in, if_ack_out;
  logic [31:0] if_addr_in, if_data_out;
  logic        mem_req_in, mem_we_in, mem_ack_out;
  logic [31:0] mem_addr_in, mem_wdata_in, mem_rdata_out;
  logic        ram_req_out, ram_we_out, ram_ready_in;
  logic [31:0] ram_addr_out, ram_wdata_out, ram_rdata_in;
  logic        stall_if_out, stall_mem_out, err_timeout_out;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk_in(clk_in), .n_rst_in(n_rst_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_data_out(if_data_out), .if_ack_out(if_ack_out),
    .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .mem_addr_in(mem_addr_in),
    .mem_wdata_in(mem_wdata_in), .mem_rdata_out(mem_rdata_out), .mem_ack_out(mem_ack_out),
    .ram_req_out(ram_req_out), .ram_we_out(ram_we_out), .ram_addr_out(ram_addr_out),
    .ram_wdata_out(ram_wdata_out), .ram_rdata_in(ram_rdata_in), .ram_ready_in(ram_ready_in),
    .stall_if_out(stall_if_out), .stall_mem_out(stall_mem_out), .err_timeout_out(err_timeout_out)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;
  vec_t vecs[6];

  // RAM responder controls
  int          resp_waits = 0;
  bit          never_ready = 0;
  bit          force_ready = 0;
  bit          use_tbl = 0;
  logic [31:0] tbl_rdata = '0;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // RAM model: inserts resp_waits wait cycles per access and checks the request stays stable
  initial begin : responder
    bit          acc_open;
    int          wait_left;
    logic [31:0] a0, d0;
    logic        w0;
    acc_open     = 0;
    wait_left    = 0;
    ram_ready_in = 1'b0;
    ram_rdata_in = '0;
    forever begin
      @(negedge clk_in);
      if (ram_req_out) begin
        if (!acc_open) begin
          acc_open  = 1;
          wait_left = resp_waits;
          a0 = ram_addr_out; d0 = ram_wdata_out; w0 = ram_we_out;
        end else begin
          check("ram_stable", {ram_we_out, ram_addr_out, ram_wdata_out}, {w0, a0, d0});
        end
        if (!never_ready && wait_left == 0) begin
          ram_ready_in = 1'b1;
          ram_rdata_in = use_tbl ? tbl_rdata : (ram_addr_out ^ K);
          acc_open     = 0;
        end else begin
          ram_ready_in = 1'b0;
          ram_rdata_in = 32'h0BAD_0BAD;
          if (wait_left > 0) wait_left--;
        end
      end else begin
        acc_open     = 0;
        ram_ready_in = force_ready;
        ram_rdata_in = 32'hEEEE_EEEE;
      end
    end
  end

  // scoreboard: every ack must match the oldest expected completion
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (if_ack_out || mem_ack_out) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {if_ack_out, mem_ack_out}, 2'b00);
        end else begin
          e = sb.pop_front();
          check("ack_port", {if_ack_out, mem_ack_out}, {!e.is_mem, e.is_mem});
          check("ack_data", e.is_mem ? mem_rdata_out : if_data_out, e.data);
        end
      end
    end
  end

  // raise one request, wait (bounded) for its ack, then drop it during the ack cycle
  task automatic run_txn(input bit is_mem, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] g_addr, output logic [31:0] g_wdata,
                         output bit g_we, output bit stall_ok);
    bit ack;
    if (is_mem) begin
      mem_we_in = we; mem_addr_in = addr; mem_wdata_in = wdata; mem_req_in = 1'b1;
    end else begin
      if_addr_in = addr; if_req_in = 1'b1;
    end
    lat = 0; stall_ok = 1; g_addr = '0; g_wdata = '0; g_we = 0;
    do begin
      @(negedge clk_in);
      lat++;
      ack = is_mem ? mem_ack_out : if_ack_out;
      if (lat == 1) begin
        g_addr = ram_addr_out; g_wdata = ram_wdata_out; g_we = ram_we_out;
      end
      if ((is_mem ? stall_mem_out : stall_if_out) != !ack) stall_ok = 0;
    end while (!ack && lat < 60);
    if (is_mem) mem_req_in = 1'b0; else if_req_in = 1'b0;
  endtask

  int          lat, lat_m, lat_i;
  logic [31:0] ga, gd, ga_m, gd_m, ga_i, gd_i;
  bit          gw, so, gw_m, so_m, gw_i, so_i;

  initial begin
    //            mem we addr          wdata         ram rdata     w  exp data      lat
    vecs[0] = '{1'b0, 1'b0, 32'h40,       32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 2};
    vecs[1] = '{1'b1, 1'b0, 32'h100,      32'h0,        32'h11112222, 1, 32'h11112222, 3};
    vecs[2] = '{1'b1, 1'b1, 32'h80,       32'h1234,     32'hBAD0BAD0, 3, 32'h11112222, 5};
    vecs[3] = '{1'b0, 1'b0, 32'h44,       32'h0,        32'hCAFEF00D, 2, 32'hCAFEF00D, 4};
    vecs[4] = '{1'b1, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 0, 32'hFFFFFFFF, 2};
    vecs[5] = '{1'b1, 1'b1, 32'hFFFFFFFC, 32'hA5A5A5A5, 32'h00000000, 7, 32'hFFFFFFFF, 9};

    n_rst_in = 1'b0;
    if_req_in = 0; if_addr_in = '0;
    mem_req_in = 0; mem_we_in = 0; mem_addr_in = '0; mem_wdata_in = '0;
    repeat (2) @(negedge clk_in);
    check("reset_ram", {ram_req_out, ram_we_out, ram_addr_out, ram_wdata_out}, '0);
    check("reset_req", {if_ack_out, mem_ack_out, err_timeout_out, if_data_out, mem_rdata_out}, '0);
    n_rst_in = 1'b1;

    // table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      use_tbl    = 1;
      tbl_rdata  = vecs[i].rdata;
      resp_waits = vecs[i].waits;
      sb.push_back('{vecs[i].is_mem, vecs[i].exp_data});
      @(negedge clk_in);
      run_txn(vecs[i].is_mem, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, ga, gd, gw, so);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_ram_addr", i), ga, vecs[i].addr);
      check($sformatf("v%0d_ram_wdata", i), gd, vecs[i].wdata);
      check($sformatf("v%0d_ram_we", i), gw, vecs[i].we);
      check($sformatf("v%0d_stall", i), so, 1'b1);
      check($sformatf("v%0d_err", i), err_timeout_out, 1'b0);
    end
    use_tbl = 0;

    // ram_ready_in high while idle and during ACK must be ignored
    force_ready = 1; resp_waits = 2;
    repeat (3) @(negedge clk_in);
    check("idle_ready_ignored", {ram_req_out, if_ack_out, mem_ack_out}, 3'b000);
    sb.push_back('{1'b0, 32'h900 ^ K});
    run_txn(1'b0, 1'b0, 32'h900, 32'h0, lat, ga, gd, gw, so);
    check("ready_ign_latency", lat, 4);
    repeat (2) @(negedge clk_in);
    check("ack_cycle_ready_ignored", {ram_req_out, if_ack_out, mem_ack_out}, 3'b000);
    force_ready = 0; resp_waits = 0;

    // simultaneous loads: MEM first, IF three cycles later
    sb.push_back('{1'b1, 32'h300 ^ K});
    sb.push_back('{1'b0, 32'h200 ^ K});
    @(negedge clk_in);
    fork
      run_txn(1'b1, 1'b0, 32'h300, 32'h0, lat_m, ga_m, gd_m, gw_m, so_m);
      run_txn(1'b0, 1'b0, 32'h200, 32'h0, lat_i, ga_i, gd_i, gw_i, so_i);
    join
    check("both_first_grant", ga_m, 32'h300);
    check("both_mem_latency", lat_m, 2);
    check("both_if_latency", lat_i, 5);
    check("both_if_stall", so_i, 1'b1);
    check("both_mem_stall", so_m, 1'b1);

    // starvation: 4 MEM grants then IF, twice (counter restarts from 0)
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) sb.push_back('{1'b1, 32'h500 ^ K});
      sb.push_back('{1'b0, 32'h400 ^ K});
    end
    @(negedge clk_in);
    mem_we_in = 0; mem_addr_in = 32'h500; mem_wdata_in = '0; mem_req_in = 1'b1;
    run_txn(1'b0, 1'b0, 32'h400, 32'h0, lat, ga, gd, gw, so);
    check("starve_if_latency1", lat, 14);
    run_txn(1'b0, 1'b0, 32'h400, 32'h0, lat, ga, gd, gw, so);
    check("starve_if_latency2", lat, 15);
    mem_req_in = 1'b0;
    check("starve_sb_drained", sb.size(), 0);

    // timeout: abort after 8 wait cycles with data 0, sticky error
    never_ready = 1;
    sb.push_back('{1'b0, 32'h0});
    @(negedge clk_in);
    run_txn(1'b0, 1'b0, 32'h600, 32'h0, lat, ga, gd, gw, so);
    check("timeout_latency", lat, 9);
    check("timeout_err_set", err_timeout_out, 1'b1);
    never_ready = 0;
    repeat (5) @(negedge clk_in);
    check("timeout_err_sticky", err_timeout_out, 1'b1);
    sb.push_back('{1'b1, 32'hA00 ^ K});
    run_txn(1'b1, 1'b0, 32'hA00, 32'h0, lat, ga, gd, gw, so);
    check("post_timeout_latency", lat, 2);
    check("err_sticky_after_txn", err_timeout_out, 1'b1);
    @(negedge clk_in);
    #2 n_rst_in = 1'b0;
    #1 check("err_cleared_by_reset", err_timeout_out, 1'b0);
    repeat (2) @(negedge clk_in);
    n_rst_in = 1'b1;

    // reset in the middle of a MEM store; IF waiting is served first afterwards
    @(negedge clk_in);
    never_ready = 1;
    if_addr_in = 32'hB00; if_req_in = 1'b1;
    mem_we_in = 1'b1; mem_addr_in = 32'hC00; mem_wdata_in = 32'h00C0FFEE; mem_req_in = 1'b1;
    repeat (4) @(negedge clk_in);
    check("busy_mem_before_reset", {ram_req_out, ram_we_out, ram_addr_out, ram_wdata_out},
          {1'b1, 1'b1, 32'hC00, 32'h00C0FFEE});
    #2 n_rst_in = 1'b0;
    mem_req_in = 1'b0;
    never_ready = 0;
    #1;
    check("midreset_ram", {ram_req_out, ram_we_out, ram_addr_out, ram_wdata_out}, '0);
    check("midreset_req", {if_ack_out, mem_ack_out, err_timeout_out, if_data_out, mem_rdata_out}, '0);
    repeat (2) @(negedge clk_in);
    sb.push_back('{1'b0, 32'hB00 ^ K});
    n_rst_in = 1'b1;
    lat = 0; ga = '0;
    do begin
      @(negedge clk_in);
      lat++;
      if (lat == 1) ga = ram_addr_out;
    end while (!if_ack_out && lat < 60);
    if_req_in = 1'b0;
    check("post_reset_first_grant", ga, 32'hB00);
    check("post_reset_latency", lat, 2);

    repeat (4) @(negedge clk_in);
    check("final_sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
